// File: rtl/cu_mem_lsu.sv
// cu_mem_lsu: memory-stage load/store unit driving a req/ack MMU port with
// lane enables, load extension, and misalign/bus-error/timeout faults.
module cu_mem_lsu #(
  parameter int XLEN = 32,
  parameter int ADDR_W = 32,
  parameter int TIMEOUT_W = 8,
  localparam int LANES = XLEN / 8,
  localparam int OFFW = $clog2(LANES)
) (
  input  logic              soc_clk,
  input  logic              MEM_reset,
  input  logic              MEM_stall,
  input  logic              memfetch_start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LANES-1:0]  bits_to_access,
  input  logic              read_or_write,
  input  logic              sign_ext,
  input  logic [XLEN-1:0]   store_data,
  output logic              mmu_req,
  output logic              mmu_we,
  output logic [ADDR_W-1:0] mmu_addr,
  output logic [LANES-1:0]  mmu_be,
  output logic [XLEN-1:0]   mmu_wdata,
  input  logic              mmu_ack,
  input  logic              mmu_err,
  input  logic [XLEN-1:0]   mmu_rdata,
  output logic [XLEN-1:0]   MEM_data,
  output logic              MEM_done,
  output logic              MEM_busy,
  output logic              MEM_fault,
  output logic [1:0]        fault_cause
);
  typedef enum logic [1:0] {IDLE, REQ, DONE, FAULT} state_t;
  localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'((1 << TIMEOUT_W) - 2);
  state_t state;
  logic [OFFW-1:0] off_q, off_in;
  logic [LANES-1:0] mask_q;
  logic sx_q, legal, sgn;
  logic [7:0] m8;
  logic [TIMEOUT_W-1:0] cnt;
  logic [XLEN-1:0] sh, ld;
  assign off_in = addr[OFFW-1:0];
  assign m8 = 8'(bits_to_access);
  assign legal = (m8 == 8'h01) || (m8 == 8'h03 && !addr[0]) ||
                 (m8 == 8'h0F && addr[1:0] == 2'b0) ||
                 (XLEN == 64 && m8 == 8'hFF && addr[2:0] == 3'b0);
  // masks are contiguous from lane 0, so the highest set lane holds the sign bit
  always_comb begin
    sh = mmu_rdata >> {off_q, 3'b0};
    sgn = 1'b0;
    ld = '0;
    for (int i = 0; i < LANES; i++)
      if (mask_q[i]) sgn = sh[8*i+7];
    for (int i = 0; i < LANES; i++)
      ld[8*i+:8] = mask_q[i] ? sh[8*i+:8] : {8{sgn & sx_q}};
  end
  always_ff @(posedge soc_clk or posedge MEM_reset) begin
    if (MEM_reset) begin
      state <= IDLE;
      off_q <= '0;
      mask_q <= '0;
      sx_q <= 1'b0;
      cnt <= '0;
      mmu_req <= 1'b0;
      mmu_we <= 1'b0;
      mmu_addr <= '0;
      mmu_be <= '0;
      mmu_wdata <= '0;
      MEM_data <= '0;
      MEM_done <= 1'b0;
      MEM_busy <= 1'b0;
      MEM_fault <= 1'b0;
      fault_cause <= 2'b00;
    end else begin
      case (state)
        IDLE: if (memfetch_start && !MEM_stall) begin
          off_q <= off_in;
          mask_q <= bits_to_access;
          sx_q <= sign_ext;
          cnt <= '0;
          mmu_we <= read_or_write;
          mmu_addr <= {addr[ADDR_W-1:OFFW], OFFW'(0)};
          mmu_be <= bits_to_access << off_in;
          mmu_wdata <= store_data << {off_in, 3'b0};
          MEM_busy <= 1'b1;
          if (legal) begin
            mmu_req <= 1'b1;
            state <= REQ;
          end else begin
            MEM_done <= 1'b1;
            MEM_fault <= 1'b1;
            fault_cause <= 2'b01;
            state <= FAULT;
          end
        end
        REQ: if (mmu_ack) begin
          mmu_req <= 1'b0;
          MEM_done <= 1'b1;
          MEM_fault <= mmu_err;
          fault_cause <= mmu_err ? 2'b10 : 2'b00;
          state <= mmu_err ? FAULT : DONE;
          if (!mmu_err && !mmu_we) MEM_data <= ld;
        end else if (cnt == LAST) begin
          mmu_req <= 1'b0;
          MEM_done <= 1'b1;
          MEM_fault <= 1'b1;
          fault_cause <= 2'b11;
          state <= FAULT;
        end else begin
          cnt <= cnt + 1'b1;
        end
        DONE, FAULT: if (!MEM_stall) begin
          MEM_done <= 1'b0;
          MEM_fault <= 1'b0;
          fault_cause <= 2'b00;
          MEM_busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cu_mem_lsu.sv
// tb_cu_mem_lsu: directed vectors for cu_mem_lsu (XLEN=32) with hand-computed
// expectations; MMU responses are driven by hand from the stimulus.
module tb_cu_mem_lsu;
  logic clk = 1'b0, rst = 1'b1, stall = 1'b0, start = 1'b0;
  logic [31:0] addr = '0, sdata = '0, rdata = '0;
  logic [3:0] mask = '0;
  logic rw = 1'b0, sx = 1'b0, ack = 1'b0, err = 1'b0;
  logic mmu_req, mmu_we, done, busy, fault;
  logic [31:0] mmu_addr, mmu_wdata, data;
  logic [3:0] mmu_be;
  logic [1:0] cause;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  always #5 clk = ~clk;
  cu_mem_lsu dut (
    .soc_clk(clk), .MEM_reset(rst), .MEM_stall(stall), .memfetch_start(start),
    .addr(addr), .bits_to_access(mask), .read_or_write(rw), .sign_ext(sx),
    .store_data(sdata), .mmu_req(mmu_req), .mmu_we(mmu_we), .mmu_addr(mmu_addr),
    .mmu_be(mmu_be), .mmu_wdata(mmu_wdata), .mmu_ack(ack), .mmu_err(err),
    .mmu_rdata(rdata), .MEM_data(data), .MEM_done(done), .MEM_busy(busy),
    .MEM_fault(fault), .fault_cause(cause)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic [31:0] a, input logic [3:0] m, input logic w,
                       input logic s, input logic [31:0] d);
    addr = a; mask = m; rw = w; sx = s; sdata = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic respond(input logic e, input logic [31:0] r);
    ack = 1'b1; err = e; rdata = r;
    @(negedge clk);
    ack = 1'b0; err = 1'b0;
  endtask
  initial begin
    @(negedge clk);
    chk("rst_req", mmu_req, 0);
    chk("rst_outs", {busy, done, fault, cause}, 0);
    chk("rst_data", data, 0);
    rst = 1'b0;
    @(negedge clk);
    // signed byte load from the top lane, zero-wait MMU
    issue(32'h1003, 4'h1, 1'b0, 1'b1, 0);
    chk("lb_req", {mmu_req, mmu_we, busy, done}, 4'b1010);
    chk("lb_be", mmu_be, 4'h8);
    chk("lb_addr", mmu_addr, 32'h1000);
    respond(1'b0, 32'h80AABBCC);
    chk("lb_done", {done, fault, mmu_req}, 3'b100);
    chk("lb_data", data, 32'hFFFFFF80);
    @(negedge clk);
    chk("lb_idle", {done, busy}, 0);
    // halfword store to the upper half
    issue(32'h2002, 4'h3, 1'b1, 1'b0, 32'h1234ABCD);
    chk("sh_we_be", {mmu_req, mmu_we, mmu_be}, 6'b11_1100);
    chk("sh_wdata", mmu_wdata, 32'hABCD0000);
    chk("sh_addr", mmu_addr, 32'h2000);
    respond(1'b0, 32'hDEADBEEF);
    chk("sh_done", {done, fault}, 2'b10);
    chk("sh_data", data, 32'hFFFFFF80);
    @(negedge clk);
    // misaligned word and illegal mask
    issue(32'h3001, 4'hF, 1'b0, 1'b0, 0);
    chk("mis_flt", {mmu_req, done, fault, cause}, 5'b0_1_1_01);
    @(negedge clk);
    chk("mis_clr", {done, busy, cause}, 0);
    issue(32'h3000, 4'h5, 1'b0, 1'b0, 0);
    chk("ill_flt", {mmu_req, done, fault, cause}, 5'b0_1_1_01);
    @(negedge clk);
    // start under stall is ignored
    stall = 1'b1; start = 1'b1; addr = 32'h4002; mask = 4'h3; rw = 1'b0; sx = 1'b0;
    repeat (2) @(negedge clk);
    chk("stall_start", {busy, mmu_req}, 0);
    stall = 1'b0;
    @(negedge clk);
    start = 1'b0;
    // unsigned half load with 5 wait cycles under stall
    stall = 1'b1;
    cyc = 0;
    for (int i = 0; i < 5; i++) begin
      if (mmu_req) cyc++;
      if (i == 4) begin ack = 1'b1; rdata = 32'hFFFF0000; end
      @(negedge clk);
    end
    ack = 1'b0;
    chk("ws_req_cycles", cyc, 5);
    chk("ws_done", {done, fault, mmu_req}, 3'b100);
    chk("lhu_data", data, 32'h0000FFFF);
    repeat (3) @(negedge clk);
    chk("ws_hold", {done, busy}, 2'b11);
    stall = 1'b0;
    @(negedge clk);
    chk("ws_release", {done, busy}, 0);
    // bus error
    issue(32'h5000, 4'hF, 1'b0, 1'b0, 0);
    respond(1'b1, 32'h11111111);
    chk("err_flt", {done, fault, cause}, 4'b1_1_10);
    chk("err_data", data, 32'h0000FFFF);
    @(negedge clk);
    // timeout after 255 request cycles
    issue(32'h6000, 4'hF, 1'b0, 1'b0, 0);
    cyc = 0;
    while (mmu_req && cyc < 300) begin cyc++; @(negedge clk); end
    chk("to_cycles", cyc, 255);
    chk("to_flt", {mmu_req, done, fault, cause}, 5'b0_1_1_11);
    @(negedge clk);
    // late ack in idle
    respond(1'b0, 32'h22222222);
    chk("late_ack", {busy, done, mmu_req}, 0);
    chk("late_data", data, 32'h0000FFFF);
    // asynchronous reset mid-request
    issue(32'h7000, 4'hF, 1'b0, 1'b0, 0);
    chk("rr_req", mmu_req, 1);
    #2 rst = 1'b1;
    #1 chk("rr_async", {mmu_req, busy, done}, 0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rr_nodone", {done, busy}, 0);
    chk("rr_data", data, 0);
    issue(32'h7004, 4'hF, 1'b0, 1'b1, 0);
    chk("rr2_req", {mmu_req, mmu_be}, 5'b1_1111);
    chk("rr2_addr", mmu_addr, 32'h7004);
    respond(1'b0, 32'h12345678);
    chk("rr2_data", {done, fault, data}, {2'b10, 32'h12345678});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
